axi_rd_arbiter: RTL and testbench

AXI_RD_ARBITER -- requirements
Module: axi_rd_arbiter

---
 rtl/axi_rd_arbiter.sv | 190 +++++++++++++++++++
 tb/tb_axi_rd_arbiter.sv | 296 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/axi_rd_arbiter.sv
// Two-requester AXI read arbiter: round-robin AR grant with an optional
// start-of-job gate on requester 1, and in-order R routing via a 1-bit
// order FIFO that remembers which requester owns each outstanding burst.
module axi_rd_arbiter #(
  parameter int unsigned C_ADDR_WIDTH      = 64,
  parameter int unsigned C_DATA_WIDTH      = 512,
  parameter int unsigned C_MAX_OUTSTANDING = 16
) (
  input  logic                                  data_clk,
  input  logic                                  data_rst_n,
  input  logic                                  ctrl_start,
  input  logic                                  cfg_nfa_first,
  input  logic                                  nfa_done_i,
  input  logic                                  s0_arvalid,
  output logic                                  s0_arready,
  input  logic [C_ADDR_WIDTH-1:0]               s0_araddr,
  input  logic [7:0]                            s0_arlen,
  output logic                                  s0_rvalid,
  input  logic                                  s0_rready,
  output logic [C_DATA_WIDTH-1:0]               s0_rdata,
  output logic                                  s0_rlast,
  input  logic                                  s1_arvalid,
  output logic                                  s1_arready,
  input  logic [C_ADDR_WIDTH-1:0]               s1_araddr,
  input  logic [7:0]                            s1_arlen,
  output logic                                  s1_rvalid,
  input  logic                                  s1_rready,
  output logic [C_DATA_WIDTH-1:0]               s1_rdata,
  output logic                                  s1_rlast,
  output logic                                  m_axi_arvalid,
  input  logic                                  m_axi_arready,
  output logic [C_ADDR_WIDTH-1:0]               m_axi_araddr,
  output logic [7:0]                            m_axi_arlen,
  input  logic                                  m_axi_rvalid,
  output logic                                  m_axi_rready,
  input  logic [C_DATA_WIDTH-1:0]               m_axi_rdata,
  input  logic                                  m_axi_rlast,
  output logic [$clog2(C_MAX_OUTSTANDING):0]    outstanding_o,
  output logic                                  busy_o,
  output logic                                  err_o
);

  localparam int unsigned PTR_W = $clog2(C_MAX_OUTSTANDING);
  localparam int unsigned CNT_W = PTR_W + 1;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_ISSUE = 1'b1
  } state_t;

  state_t                   r_state;
  state_t                   w_state_nxt;
  logic                     r_gate;
  logic                     r_last_grant;
  logic                     r_err;
  logic [C_ADDR_WIDTH-1:0]  r_araddr;
  logic [7:0]               r_arlen;
  logic [C_MAX_OUTSTANDING-1:0] r_order;
  logic [PTR_W-1:0]         r_wr_ptr;
  logic [PTR_W-1:0]         r_rd_ptr;
  logic [CNT_W-1:0]         r_count;

  logic w_full;
  logic w_empty;
  logic w_elig0;
  logic w_elig1;
  logic w_grant0;
  logic w_grant1;
  logic w_push;
  logic w_pop;
  logic w_head;
  logic w_rsel0;
  logic w_rsel1;
  logic w_start;

  assign w_full  = (r_count == CNT_W'(C_MAX_OUTSTANDING));
  assign w_empty = (r_count == '0);

  // Reset term keeps arready low while data_rst_n is held, even though the FSM sits in IDLE.
  assign w_elig0 = data_rst_n && (r_state == ST_IDLE) && s0_arvalid && !w_full;
  assign w_elig1 = data_rst_n && (r_state == ST_IDLE) && s1_arvalid && !w_full && !r_gate;

  // AR state register
  always_ff @(posedge data_clk or negedge data_rst_n) begin
    if (!data_rst_n) r_state <= ST_IDLE;
    else             r_state <= w_state_nxt;
  end

  // Next-state and round-robin grant decode
  always_comb begin
    w_state_nxt = r_state;
    w_grant0    = 1'b0;
    w_grant1    = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (w_elig0 && (!w_elig1 || r_last_grant)) begin
          w_grant0    = 1'b1;
          w_state_nxt = ST_ISSUE;
        end else if (w_elig1) begin
          w_grant1    = 1'b1;
          w_state_nxt = ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        if (m_axi_arready) w_state_nxt = ST_IDLE;
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  assign s0_arready    = w_grant0;
  assign s1_arready    = w_grant1;
  assign m_axi_arvalid = (r_state == ST_ISSUE);
  assign m_axi_araddr  = r_araddr;
  assign m_axi_arlen   = r_arlen;
  assign w_push        = m_axi_arvalid && m_axi_arready;

  assign busy_o  = !w_empty || (r_state != ST_IDLE);
  assign w_start = ctrl_start && !busy_o;

  // Capture granted request; last_grant doubles as the pending burst's owner ID
  always_ff @(posedge data_clk or negedge data_rst_n) begin
    if (!data_rst_n) begin
      r_araddr     <= '0;
      r_arlen      <= '0;
      r_last_grant <= 1'b1;
    end else if (w_grant0) begin
      r_araddr     <= s0_araddr;
      r_arlen      <= s0_arlen;
      r_last_grant <= 1'b0;
    end else if (w_grant1) begin
      r_araddr     <= s1_araddr;
      r_arlen      <= s1_arlen;
      r_last_grant <= 1'b1;
    end else if (w_start) begin
      r_last_grant <= 1'b1;
    end
  end

  // Requester-1 gate: armed at job start, released by nfa_done_i
  always_ff @(posedge data_clk or negedge data_rst_n) begin
    if (!data_rst_n)     r_gate <= 1'b0;
    else if (w_start)    r_gate <= cfg_nfa_first && !nfa_done_i;
    else if (nfa_done_i) r_gate <= 1'b0;
  end

  // R routing follows the owner of the oldest outstanding burst
  assign w_head       = r_order[r_rd_ptr];
  assign w_rsel0      = !w_empty && !w_head;
  assign w_rsel1      = !w_empty &&  w_head;
  assign s0_rvalid    = w_rsel0 && m_axi_rvalid;
  assign s1_rvalid    = w_rsel1 && m_axi_rvalid;
  assign s0_rdata     = m_axi_rdata;
  assign s1_rdata     = m_axi_rdata;
  assign s0_rlast     = m_axi_rlast;
  assign s1_rlast     = m_axi_rlast;
  assign m_axi_rready = (w_rsel0 && s0_rready) || (w_rsel1 && s1_rready);
  assign w_pop        = m_axi_rvalid && m_axi_rready && m_axi_rlast;

  // Order FIFO: push owner on AR handshake, pop on last R beat
  always_ff @(posedge data_clk or negedge data_rst_n) begin
    if (!data_rst_n) begin
      r_order  <= '0;
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) begin
        r_order[r_wr_ptr] <= r_last_grant;
        r_wr_ptr          <= r_wr_ptr + PTR_W'(1);
      end
      if (w_pop) r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CNT_W'(1);
        2'b01:   r_count <= r_count - CNT_W'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  // Sticky error: R beat with nothing outstanding
  always_ff @(posedge data_clk or negedge data_rst_n) begin
    if (!data_rst_n)                 r_err <= 1'b0;
    else if (m_axi_rvalid && w_empty) r_err <= 1'b1;
  end

  assign outstanding_o = r_count;
  assign err_o         = r_err;

endmodule

// File: tb/tb_axi_rd_arbiter.sv
// Directed bench for axi_rd_arbiter: grant order, gate, FIFO full, R routing, error, reset.
module tb_axi_rd_arbiter;

  localparam int unsigned AW = 32;
  localparam int unsigned DW = 32;
  localparam int unsigned MO = 16;

  logic            data_clk;
  logic            data_rst_n;
  logic            ctrl_start;
  logic            cfg_nfa_first;
  logic            nfa_done_i;
  logic            s0_arvalid, s0_arready, s0_rvalid, s0_rready, s0_rlast;
  logic [AW-1:0]   s0_araddr;
  logic [7:0]      s0_arlen;
  logic [DW-1:0]   s0_rdata;
  logic            s1_arvalid, s1_arready, s1_rvalid, s1_rready, s1_rlast;
  logic [AW-1:0]   s1_araddr;
  logic [7:0]      s1_arlen;
  logic [DW-1:0]   s1_rdata;
  logic            m_axi_arvalid, m_axi_arready, m_axi_rvalid, m_axi_rready, m_axi_rlast;
  logic [AW-1:0]   m_axi_araddr;
  logic [7:0]      m_axi_arlen;
  logic [DW-1:0]   m_axi_rdata;
  logic [$clog2(MO):0] outstanding_o;
  logic            busy_o;
  logic            err_o;

  int n_pass  = 0;
  int n_total = 0;
  int cyc     = 0;

  logic            rx_en    = 1'b0;
  logic            both_err = 1'b0;
  logic [DW+1:0]   rx_q[$];

  axi_rd_arbiter #(
    .C_ADDR_WIDTH(AW), .C_DATA_WIDTH(DW), .C_MAX_OUTSTANDING(MO)
  ) dut (
    .data_clk(data_clk), .data_rst_n(data_rst_n),
    .ctrl_start(ctrl_start), .cfg_nfa_first(cfg_nfa_first), .nfa_done_i(nfa_done_i),
    .s0_arvalid(s0_arvalid), .s0_arready(s0_arready), .s0_araddr(s0_araddr), .s0_arlen(s0_arlen),
    .s0_rvalid(s0_rvalid), .s0_rready(s0_rready), .s0_rdata(s0_rdata), .s0_rlast(s0_rlast),
    .s1_arvalid(s1_arvalid), .s1_arready(s1_arready), .s1_araddr(s1_araddr), .s1_arlen(s1_arlen),
    .s1_rvalid(s1_rvalid), .s1_rready(s1_rready), .s1_rdata(s1_rdata), .s1_rlast(s1_rlast),
    .m_axi_arvalid(m_axi_arvalid), .m_axi_arready(m_axi_arready),
    .m_axi_araddr(m_axi_araddr), .m_axi_arlen(m_axi_arlen),
    .m_axi_rvalid(m_axi_rvalid), .m_axi_rready(m_axi_rready),
    .m_axi_rdata(m_axi_rdata), .m_axi_rlast(m_axi_rlast),
    .outstanding_o(outstanding_o), .busy_o(busy_o), .err_o(err_o)
  );

  initial begin
    data_clk = 1'b0;
    forever #5 data_clk = ~data_clk;
  end

  // Cycle counter and R-beat monitor
  always @(posedge data_clk) begin
    cyc = cyc + 1;
    if (rx_en) begin
      if (s0_rvalid && s0_rready) rx_q.push_back({1'b0, s0_rlast, s0_rdata});
      if (s1_rvalid && s1_rready) rx_q.push_back({1'b1, s1_rlast, s1_rdata});
      if (s0_rvalid && s1_rvalid) both_err = 1'b1;
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog obs=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge data_clk);
    #1;
  endtask

  task automatic start(input logic f);
    ctrl_start    = 1'b1;
    cfg_nfa_first = f;
    tick();
    ctrl_start    = 1'b0;
    cfg_nfa_first = 1'b0;
  endtask

  // Request one burst from requester id and let it pass through ISSUE
  task automatic issue(input logic id, input logic [AW-1:0] a, input logic [7:0] l);
    logic ok = 1'b0;
    if (id) begin s1_arvalid = 1'b1; s1_araddr = a; s1_arlen = l; end
    else    begin s0_arvalid = 1'b1; s0_araddr = a; s0_arlen = l; end
    for (int i = 0; i < 20 && !ok; i++) begin
      #1;
      ok = id ? s1_arready : s0_arready;
      tick();
    end
    s0_arvalid = 1'b0;
    s1_arvalid = 1'b0;
    chk("ar_grant", 64'(ok), 64'(1));
    chk("ar_addr", 64'(m_axi_araddr), 64'(a));
    chk("ar_len", 64'(m_axi_arlen), 64'(l));
    tick();
  endtask

  int          g_id[$];
  int          g_cyc[$];
  int          n0, n1, ng;
  logic        g0, g1, early, hs;
  logic [AW-1:0] last_addr;
  logic        exp_id[6]   = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0};
  logic        exp_last[6] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1};
  logic [DW+1:0] e;

  initial begin
    data_rst_n = 1'b0; ctrl_start = 1'b0; cfg_nfa_first = 1'b0; nfa_done_i = 1'b0;
    s0_arvalid = 1'b1; s0_araddr = '0; s0_arlen = '0; s0_rready = 1'b1;
    s1_arvalid = 1'b1; s1_araddr = '0; s1_arlen = '0; s1_rready = 1'b1;
    m_axi_arready = 1'b1; m_axi_rvalid = 1'b1; m_axi_rdata = '0; m_axi_rlast = 1'b1;
    last_addr = '0;

    // Outputs held low during reset even with requests present
    #2;
    chk("rst_s0_arready", 64'(s0_arready), 64'(0));
    chk("rst_s1_arready", 64'(s1_arready), 64'(0));
    chk("rst_m_arvalid", 64'(m_axi_arvalid), 64'(0));
    chk("rst_m_rready", 64'(m_axi_rready), 64'(0));
    chk("rst_rvalid", 64'({s0_rvalid, s1_rvalid}), 64'(0));
    chk("rst_outstanding", 64'(outstanding_o), 64'(0));
    chk("rst_busy", 64'(busy_o), 64'(0));
    chk("rst_err", 64'(err_o), 64'(0));
    s0_arvalid = 1'b0; s1_arvalid = 1'b0; m_axi_rvalid = 1'b0;
    tick(); tick();
    data_rst_n = 1'b1;
    tick();
    chk("post_rst_busy", 64'(busy_o), 64'(0));

    // Round-robin with both requesters holding arvalid
    s0_araddr = 32'h1000; s1_araddr = 32'h2000;
    start(1'b0);
    s0_arvalid = 1'b1; s1_arvalid = 1'b1; n0 = 0; n1 = 0;
    for (int c = 0; c < 40; c++) begin
      #1;
      g0 = s0_arvalid && s0_arready;
      g1 = s1_arvalid && s1_arready;
      if (g0) begin g_id.push_back(0); g_cyc.push_back(cyc); last_addr = s0_araddr; end
      if (g1) begin g_id.push_back(1); g_cyc.push_back(cyc); last_addr = s1_araddr; end
      if (m_axi_arvalid) chk("rr_araddr", 64'(m_axi_araddr), 64'(last_addr));
      tick();
      if (g0) begin n0++; s0_araddr = s0_araddr + 32'h40; if (n0 == 4) s0_arvalid = 1'b0; end
      if (g1) begin n1++; s1_araddr = s1_araddr + 32'h40; if (n1 == 4) s1_arvalid = 1'b0; end
    end
    chk("rr_grant_count", 64'(g_id.size()), 64'(8));
    for (int i = 0; i < 8 && i < g_id.size(); i++) begin
      chk("rr_order", 64'(g_id[i]), 64'(i % 2));
      if (i > 0) chk("rr_spacing", 64'(g_cyc[i] - g_cyc[i-1]), 64'(2));
    end
    chk("rr_outstanding", 64'(outstanding_o), 64'(8));
    chk("rr_busy", 64'(busy_o), 64'(1));
    for (int k = 0; k < 8; k++) begin
      m_axi_rvalid = 1'b1; m_axi_rlast = 1'b1; m_axi_rdata = DW'(k);
      #1;
      chk("rr_r_s0", 64'(s0_rvalid), 64'(k % 2 == 0));
      chk("rr_r_s1", 64'(s1_rvalid), 64'(k % 2 == 1));
      tick();
    end
    m_axi_rvalid = 1'b0;
    chk("rr_drained", 64'(outstanding_o), 64'(0));

    // Gate: requester 1 blocked until the cycle after nfa_done_i
    start(1'b1);
    s1_arvalid = 1'b1; s1_araddr = 32'h5000; s1_arlen = 8'd0; early = 1'b0;
    for (int rel = 1; rel <= 20; rel++) begin
      if (rel == 20) nfa_done_i = 1'b1;
      #1;
      if (s1_arready) early = 1'b1;
      tick();
      nfa_done_i = 1'b0;
    end
    chk("gate_no_early_grant", 64'(early), 64'(0));
    #1;
    chk("gate_release_grant", 64'(s1_arready), 64'(1));
    tick();
    s1_arvalid = 1'b0;
    chk("gate_araddr", 64'(m_axi_araddr), 64'(32'h5000));
    tick();
    m_axi_rvalid = 1'b1; m_axi_rlast = 1'b1;
    #1;
    chk("gate_r_s1", 64'({s0_rvalid, s1_rvalid}), 64'(2'b01));
    tick();
    m_axi_rvalid = 1'b0;
    chk("gate_drained", 64'(outstanding_o), 64'(0));

    // Order FIFO full at 16 outstanding
    s0_arvalid = 1'b1; s0_araddr = 32'h4000; s0_arlen = 8'd3; ng = 0;
    for (int c = 0; c < 40; c++) begin
      #1;
      if (s0_arready) ng++;
      tick();
    end
    chk("full_grants", 64'(ng), 64'(16));
    chk("full_outstanding", 64'(outstanding_o), 64'(16));
    m_axi_rvalid = 1'b1; m_axi_rlast = 1'b1;
    #1;
    chk("full_no_arready", 64'(s0_arready), 64'(0));
    chk("full_m_rready", 64'(m_axi_rready), 64'(1));
    tick();
    m_axi_rvalid = 1'b0;
    chk("full_pop_outstanding", 64'(outstanding_o), 64'(15));
    #1;
    chk("full_regrant", 64'(s0_arready), 64'(1));
    tick();
    s0_arvalid = 1'b0;
    tick();
    chk("full_refill", 64'(outstanding_o), 64'(16));
    for (int k = 0; k < 16; k++) begin
      m_axi_rvalid = 1'b1; m_axi_rlast = 1'b1;
      tick();
    end
    m_axi_rvalid = 1'b0;
    chk("full_drained", 64'(outstanding_o), 64'(0));

    // Interleaved bursts with random rready stalls
    issue(1'b0, 32'h3000, 8'd1);
    issue(1'b1, 32'h3100, 8'd2);
    issue(1'b0, 32'h3200, 8'd0);
    chk("il_outstanding", 64'(outstanding_o), 64'(3));
    rx_en = 1'b1;
    for (int b = 0; b < 6; b++) begin
      m_axi_rvalid = 1'b1; m_axi_rdata = DW'(32'hA0 + b); m_axi_rlast = exp_last[b];
      hs = 1'b0;
      for (int t = 0; t < 30 && !hs; t++) begin
        s0_rready = (t >= 3) ? 1'b1 : 1'($urandom_range(0, 1));
        s1_rready = (t >= 3) ? 1'b1 : 1'($urandom_range(0, 1));
        #1;
        hs = m_axi_rready;
        tick();
      end
      chk("il_beat_accepted", 64'(hs), 64'(1));
    end
    m_axi_rvalid = 1'b0; s0_rready = 1'b1; s1_rready = 1'b1;
    tick();
    rx_en = 1'b0;
    chk("il_beat_count", 64'(rx_q.size()), 64'(6));
    for (int i = 0; i < 6 && i < rx_q.size(); i++) begin
      e = {exp_id[i], exp_last[i], DW'(32'hA0 + i)};
      chk("il_beat", 64'(rx_q[i]), 64'(e));
    end
    chk("il_no_dual_rvalid", 64'(both_err), 64'(0));
    chk("il_drained", 64'(outstanding_o), 64'(0));

    // R beat with nothing outstanding
    m_axi_rvalid = 1'b1; m_axi_rlast = 1'b1;
    #1;
    chk("err_m_rready", 64'(m_axi_rready), 64'(0));
    chk("err_rvalid", 64'({s0_rvalid, s1_rvalid}), 64'(0));
    tick();
    m_axi_rvalid = 1'b0;
    chk("err_set", 64'(err_o), 64'(1));
    tick(); tick(); tick();
    chk("err_sticky", 64'(err_o), 64'(1));

    // Async reset while in ISSUE with 3 bursts outstanding
    issue(1'b0, 32'h6000, 8'd0);
    issue(1'b1, 32'h6100, 8'd0);
    issue(1'b0, 32'h6200, 8'd0);
    m_axi_arready = 1'b0;
    issue(1'b1, 32'h6300, 8'd0);
    chk("mid_outstanding", 64'(outstanding_o), 64'(3));
    chk("mid_arvalid", 64'(m_axi_arvalid), 64'(1));
    s0_arvalid = 1'b1;
    #1;
    data_rst_n = 1'b0;
    #1;
    chk("arst_arvalid", 64'(m_axi_arvalid), 64'(0));
    chk("arst_outstanding", 64'(outstanding_o), 64'(0));
    chk("arst_busy", 64'(busy_o), 64'(0));
    chk("arst_s0_arready", 64'(s0_arready), 64'(0));
    chk("arst_err", 64'(err_o), 64'(0));
    s0_arvalid = 1'b0; m_axi_arready = 1'b1;
    tick();
    data_rst_n = 1'b1;
    tick();
    chk("arst_release_outstanding", 64'(outstanding_o), 64'(0));
    chk("arst_release_busy", 64'(busy_o), 64'(0));

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
